// File: rtl/recip_nr_refine.sv
// Newton-Raphson refinement of a reciprocal seed: x <- x*(2 - d*x), NITER passes
// through one shared (F+2)x(F+2) multiplier, one operand in flight at a time.
module recip_nr_refine #(
  parameter int unsigned NSIG    = 10,
  parameter int unsigned X0WIDTH = 8,
  parameter int unsigned NITER   = 2,
  parameter int unsigned F       = NSIG + 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NSIG:0]    d_in,
  input  logic [X0WIDTH-1:0] seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [F:0]       x_out
);

  localparam int unsigned W  = F + 2;
  localparam int unsigned MW = 2 * W;
  localparam int unsigned XW = F + 1;
  localparam int unsigned DW = NSIG + 1;
  localparam int unsigned CW = $clog2(NITER + 1);
  localparam logic [W-1:0] TWO = {1'b1, {(F + 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_E, MUL_X, DONE} state_t;

  state_t          state, nextState;
  logic [DW-1:0]   dR;
  logic [XW-1:0]   xR;
  logic [W-1:0]    tR;
  logic [CW-1:0]   iterCnt;
  logic [W-1:0]    mulA, mulB;
  logic [MW-1:0]   prod;
  logic [W-1:0]    eVal, tNext;
  logic [XW-1:0]   xNext;
  logic            lastIter;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  assign lastIter = (iterCnt + CW'(1)) == CW'(NITER);

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = MUL_E;
      MUL_E:   nextState = MUL_X;
      MUL_X:   nextState = lastIter ? DONE : MUL_E;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Shared multiplier: d*x for the error term, x*t for the update
  always_comb begin
    mulA = W'(dR);
    mulB = W'(xR);
    if (state == MUL_X) begin
      mulA = W'(xR);
      mulB = tR;
    end
  end

  assign prod  = MW'(mulA) * MW'(mulB);
  assign eVal  = W'(prod >> NSIG);
  assign tNext = TWO - eVal;
  assign xNext = XW'(prod >> F);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dR      <= '0;
      xR      <= '0;
      tR      <= '0;
      iterCnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dR      <= d_in;
          xR      <= {1'b0, seed_in, {(F - X0WIDTH){1'b0}}};
          iterCnt <= '0;
        end
        MUL_E: tR <= tNext;
        MUL_X: begin
          xR      <= xNext;
          iterCnt <= iterCnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign x_out = xR;

endmodule
